// File: rtl/spi_display_pkg.sv
// Shared definitions for the display SPI link: command codes, field widths
// and the receiver decode-state encoding.
package spi_display_pkg;

    localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
    localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
    localparam logic [7:0] CMD_WRITE_RAM  = 8'h2C;

    localparam int COORD_W = 9;
    localparam int COLOR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_PASET = 2'd2,
        ST_RAMWR = 2'd3
    } rx_state_e;

    function automatic rx_state_e cmd_to_state(input logic [7:0] cmd);
        case (cmd)
            CMD_SET_COLUMN: return ST_CASET;
            CMD_SET_PAGE:   return ST_PASET;
            CMD_WRITE_RAM:  return ST_RAMWR;
            default:        return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte assembler: synchronises SCLK/MOSI/DC/CS into i_clk, shifts bits on
// SCLK rising edges and emits one strobe per completed byte.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_dc,
    input  logic       i_cs,
    output logic [7:0] o_byte,
    output logic       o_byte_dc,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    // Bit order in each stage: {sclk, mosi, dc, cs}; cs idles high.
    localparam logic [3:0] SYNC_RST = 4'b0001;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, dc_s, cs_s;
    logic sclk_rise, cs_rise, shift_en;

    assign sclk_s = sync_q[SYNC_STAGES-1][3];
    assign mosi_s = sync_q[SYNC_STAGES-1][2];
    assign dc_s   = sync_q[SYNC_STAGES-1][1];
    assign cs_s   = sync_q[SYNC_STAGES-1][0];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // An edge that coincides with CS rising still belongs to the frame.
    assign shift_en  = sclk_rise & (~cs_s | cs_rise);

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (shift_en) begin
            if (bit_cnt_q == 3'd7) begin
                byte_d       = {shift_q, mosi_s};
                byte_dc_d    = dc_s;
                byte_valid_d = 1'b1;
                bit_cnt_d    = 3'd0;
            end else begin
                shift_d   = {shift_q[5:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
        if (cs_rise) begin
            frame_err_d = (bit_cnt_d != 3'd0);
            bit_cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q       <= {SYNC_STAGES{SYNC_RST}};
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_q       <= '0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], {i_sclk, i_mosi, i_dc, i_cs}};
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_dc    = byte_dc_q;
    assign o_byte_valid = byte_valid_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: rtl/spi_display_rx.sv
// Display SPI responder: decodes CASET/PASET/RAMWR into per-pixel write strobes.
// Optional pixel counter output enabled by SPI_DISPLAY_RX_PIXCNT_EN.
module spi_display_rx
    import spi_display_pkg::*;
#(
    parameter int H_RES       = 240,
    parameter int V_RES       = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sclk,
    input  logic               i_mosi,
    input  logic               i_dc,
    input  logic               i_cs,
    output logic               o_cmd_valid,
    output logic [7:0]         o_cmd,
    output logic               o_px_valid,
    output logic [COORD_W-1:0] o_px_x,
    output logic [COORD_W-1:0] o_px_y,
    output logic [COLOR_W-1:0] o_px_color,
    output logic               o_err
`ifdef SPI_DISPLAY_RX_PIXCNT_EN
    , output logic [17:0]      o_px_count
`endif
);

    localparam logic [COORD_W:0]   H_LIM  = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]   V_LIM  = (COORD_W+1)'(V_RES);
    localparam logic [COORD_W-1:0] EC_RST = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] EP_RST = COORD_W'(V_RES - 1);

    logic [7:0] rx_byte;
    logic       rx_dc, rx_valid, frame_err;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sclk      (i_sclk),
        .i_mosi      (i_mosi),
        .i_dc        (i_dc),
        .i_cs        (i_cs),
        .o_byte      (rx_byte),
        .o_byte_dc   (rx_dc),
        .o_byte_valid(rx_valid),
        .o_frame_err (frame_err)
    );

    rx_state_e state_q, state_d;

    logic [1:0]         pcnt_q;
    logic [COORD_W-1:0] start_q;
    logic               end_hi_q;
    logic [COORD_W-1:0] sc_q, ec_q, sp_q, ep_q;
    logic [COORD_W-1:0] cur_x_q, cur_y_q;
    logic [7:0]         hi_q;
    logic               phase_q;
    logic [7:0]         cmd_q;
    logic               px_valid_q, win_err_q;
    logic [COORD_W-1:0] px_x_q, px_y_q;
    logic [COLOR_W-1:0] px_color_q;

    logic               cmd_stb, data_stb, in_param, param_last, win_ok;
    logic               enter_ramwr, px_fire;
    logic [COORD_W-1:0] end_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_stb)         state_d = cmd_to_state(rx_byte);
        else if (param_last) state_d = ST_IDLE;
    end

    always_comb begin
        cmd_stb     = rx_valid & ~rx_dc;
        data_stb    = rx_valid & rx_dc;
        in_param    = (state_q == ST_CASET) || (state_q == ST_PASET);
        param_last  = data_stb & in_param & (pcnt_q == 2'd3);
        end_v       = {end_hi_q, rx_byte};
        win_ok      = (start_q <= end_v) &&
                      ({1'b0, end_v} < ((state_q == ST_CASET) ? H_LIM : V_LIM));
        enter_ramwr = cmd_stb & (rx_byte == CMD_WRITE_RAM);
        px_fire     = data_stb & (state_q == ST_RAMWR) & phase_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt_q     <= '0;
            start_q    <= '0;
            end_hi_q   <= 1'b0;
            sc_q       <= '0;
            ec_q       <= EC_RST;
            sp_q       <= '0;
            ep_q       <= EP_RST;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            hi_q       <= '0;
            phase_q    <= 1'b0;
            cmd_q      <= '0;
            px_valid_q <= 1'b0;
            win_err_q  <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_color_q <= '0;
        end else begin
            px_valid_q <= px_fire;
            win_err_q  <= param_last & ~win_ok;
            if (cmd_stb) begin
                cmd_q   <= rx_byte;
                pcnt_q  <= '0;
                phase_q <= 1'b0;
                if (enter_ramwr) begin
                    cur_x_q <= sc_q;
                    cur_y_q <= sp_q;
                end
            end else if (data_stb && in_param) begin
                pcnt_q <= pcnt_q + 2'd1;
                case (pcnt_q)
                    2'd0:    start_q[8]   <= rx_byte[0];
                    2'd1:    start_q[7:0] <= rx_byte;
                    2'd2:    end_hi_q     <= rx_byte[0];
                    default: begin
                        if (win_ok && state_q == ST_CASET) begin
                            sc_q <= start_q;
                            ec_q <= end_v;
                        end
                        if (win_ok && state_q == ST_PASET) begin
                            sp_q <= start_q;
                            ep_q <= end_v;
                        end
                    end
                endcase
            end else if (data_stb && state_q == ST_RAMWR) begin
                phase_q <= ~phase_q;
                if (!phase_q) hi_q <= rx_byte;
            end
            // Pixel emission and raster-order cursor step inside the window.
            if (px_fire) begin
                px_x_q     <= cur_x_q;
                px_y_q     <= cur_y_q;
                px_color_q <= {hi_q, rx_byte};
                if (cur_x_q == ec_q) begin
                    cur_x_q <= sc_q;
                    cur_y_q <= (cur_y_q == ep_q) ? sp_q : cur_y_q + 1'b1;
                end else begin
                    cur_x_q <= cur_x_q + 1'b1;
                end
            end
        end
    end

`ifdef SPI_DISPLAY_RX_PIXCNT_EN
    logic [17:0] px_count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                        px_count_q <= '0;
        else if (enter_ramwr)                px_count_q <= '0;
        else if (px_fire && ~&px_count_q)    px_count_q <= px_count_q + 18'd1;
    end

    assign o_px_count = px_count_q;
`endif

    assign o_cmd_valid = cmd_stb;
    assign o_cmd       = cmd_stb ? rx_byte : cmd_q;
    assign o_px_valid  = px_valid_q;
    assign o_px_x      = px_x_q;
    assign o_px_y      = px_y_q;
    assign o_px_color  = px_color_q;
    assign o_err       = frame_err | win_err_q;

endmodule

// File: tb/tb_spi_display_rx.sv
// Bench for spi_display_rx: directed scenarios plus a random byte stream,
// scored against a window/pixel-index model of the display protocol.
module tb_spi_display_rx;

    localparam int H = 240;
    localparam int V = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0, mosi = 1'b0, dc = 1'b0, cs = 1'b1;
    logic        cmd_valid, px_valid, err;
    logic [7:0]  cmd;
    logic [8:0]  px_x, px_y;
    logic [15:0] px_color;
`ifdef SPI_DISPLAY_RX_PIXCNT_EN
    logic [17:0] px_count;
`endif

    spi_display_rx dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .i_dc       (dc),
        .i_cs       (cs),
        .o_cmd_valid(cmd_valid),
        .o_cmd      (cmd),
        .o_px_valid (px_valid),
        .o_px_x     (px_x),
        .o_px_y     (px_y),
        .o_px_color (px_color),
        .o_err      (err)
`ifdef SPI_DISPLAY_RX_PIXCNT_EN
        , .o_px_count(px_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: window bounds plus a linear pixel index into it.
    int         mode;           // 0 idle, 1 column, 2 page, 3 ram write
    logic [7:0] pbuf [4];
    int         pcnt, sc, ec, sp, ep, idx;
    logic [7:0] hi;
    bit         have_hi;
    int         exp_err = 0, seen_err = 0, px_seen = 0, cmd_seen = 0;
    logic [7:0]  q_cmd [$];
    int          q_x [$], q_y [$];
    logic [15:0] q_col [$];
    int          last_x = 0;

    task automatic model_reset();
        mode = 0; pcnt = 0; idx = 0; have_hi = 0;
        sc = 0; ec = H - 1; sp = 0; ep = V - 1;
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        int s, e, lim, w, h;
        if (!d) begin
            q_cmd.push_back(b);
            pcnt = 0; have_hi = 0;
            case (b)
                8'h2A:   mode = 1;
                8'h2B:   mode = 2;
                8'h2C:   begin mode = 3; idx = 0; end
                default: mode = 0;
            endcase
        end else if (mode == 1 || mode == 2) begin
            pbuf[pcnt] = b;
            pcnt++;
            if (pcnt == 4) begin
                s   = ((pbuf[0] * 256) + pbuf[1]) % 512;
                e   = ((pbuf[2] * 256) + pbuf[3]) % 512;
                lim = (mode == 1) ? H : V;
                if (s <= e && e < lim) begin
                    if (mode == 1) begin sc = s; ec = e; end
                    else           begin sp = s; ep = e; end
                end else begin
                    exp_err++;
                end
                mode = 0; pcnt = 0;
            end
        end else if (mode == 3) begin
            if (!have_hi) begin
                hi = b; have_hi = 1;
            end else begin
                w = ec - sc + 1;
                h = ep - sp + 1;
                q_x.push_back(sc + idx % w);
                q_y.push_back(sp + (idx / w) % h);
                q_col.push_back({hi, b});
                idx = (idx + 1) % (w * h);
                have_hi = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                cmd_seen++;
                if (q_cmd.size() == 0) chk_val("cmd_extra", 32'(cmd), 32'hFFFF_FFFF);
                else                   chk_val("cmd", 32'(cmd), 32'(q_cmd.pop_front()));
            end
            if (px_valid) begin
                px_seen++;
                if (q_x.size() == 0) begin
                    chk_val("px_extra", 32'(px_x), 32'hFFFF_FFFF);
                end else begin
                    last_x = q_x.pop_front();
                    chk_val("px_x", 32'(px_x), 32'(last_x));
                    chk_val("px_y", 32'(px_y), 32'(q_y.pop_front()));
                    chk_val("px_color", 32'(px_color), 32'(q_col.pop_front()));
                end
            end
            if (err) seen_err++;
        end
    end

    task automatic cs_low();
        if (cs) begin cs = 1'b0; #40; end
    endtask

    task automatic cs_high();
        if (!cs) begin cs = 1'b1; #80; end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        cs_low();
        model_byte(d, b);
        dc = d;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic send_partial(input int n);
        cs_low();
        dc = 1'b1;
        for (int i = 0; i < n; i++) begin
            mosi = 1'($urandom);
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        exp_err++;
        cs = 1'b1;
        #80;
    endtask

    task automatic send_window(input logic [7:0] c, input int s, input int e, input int np);
        logic [8:0] s9, e9;
        logic [6:0] junk;
        logic [7:0] pb [4];
        s9 = 9'(s); e9 = 9'(e);
        junk = 7'($urandom); pb[0] = {junk, s9[8]};
        pb[1] = s9[7:0];
        junk = 7'($urandom); pb[2] = {junk, e9[8]};
        pb[3] = e9[7:0];
        send_byte(1'b0, c);
        for (int i = 0; i < np; i++) send_byte(1'b1, pb[i]);
    endtask

    task automatic checkpoint();
        #400;
        chk_val("px_left", 32'(q_x.size()), 32'd0);
        chk_val("cmd_left", 32'(q_cmd.size()), 32'd0);
        chk_val("err_count", 32'(seen_err), 32'(exp_err));
    endtask

    task automatic check_outputs_zero();
        chk_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk_val("rst_cmd", 32'(cmd), 32'd0);
        chk_val("rst_px_valid", 32'(px_valid), 32'd0);
        chk_val("rst_px_x", 32'(px_x), 32'd0);
        chk_val("rst_px_y", 32'(px_y), 32'd0);
        chk_val("rst_px_color", 32'(px_color), 32'd0);
        chk_val("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        int p0, c0, e0, r, s, e, lim;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Horizontal line x=10..19 at y=50
        p0 = px_seen; c0 = cmd_seen;
        send_window(8'h2A, 10, 19, 4);
        send_window(8'h2B, 50, 50, 4);
        send_byte(1'b0, 8'h2C);
        repeat (20) send_byte(1'b1, 8'hFF);
        checkpoint();
        chk_val("hline_px", 32'(px_seen - p0), 32'd10);
        chk_val("hline_cmds", 32'(cmd_seen - c0), 32'd3);
        chk_val("px_hold", 32'(px_x), 32'(last_x));

        // Wrap within the same window
        p0 = px_seen;
        send_byte(1'b0, 8'h2C);
        repeat (160) send_byte(1'b1, 8'hFF);
        checkpoint();
        chk_val("wrap_px", 32'(px_seen - p0), 32'd80);

        // Multi-row window with wrap back to the top-left corner
        send_window(8'h2A, 0, 1, 4);
        send_window(8'h2B, 5, 6, 4);
        send_byte(1'b0, 8'h2C);
        repeat (10) send_byte(1'b1, 8'($urandom));
        checkpoint();

        // Rejected window keeps the old start column
        e0 = seen_err;
        send_window(8'h2A, 20, 10, 4);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
        checkpoint();
        chk_val("badwin_err", 32'(seen_err - e0), 32'd1);

        // CS drop after 5 bits, then a normal pixel
        e0 = seen_err; p0 = px_seen;
        send_partial(5);
        send_byte(1'b1, 8'hA5); send_byte(1'b1, 8'h5A);
        checkpoint();
        chk_val("partial_err", 32'(seen_err - e0), 32'd1);
        chk_val("partial_px", 32'(px_seen - p0), 32'd1);

        // Random protocol traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                send_partial($urandom_range(1, 7));
            end else if (r < 18) begin
                lim = (r < 13) ? H : V;
                if ($urandom_range(0, 4) == 0) begin
                    s = $urandom_range(0, 511); e = $urandom_range(0, 511);
                end else begin
                    s = $urandom_range(0, lim - 1);
                    e = $urandom_range(s, (s + 7 < lim) ? s + 7 : lim - 1);
                end
                send_window((r < 13) ? 8'h2A : 8'h2B, s, e,
                            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 4);
            end else if (r < 26) begin
                send_byte(1'b0, 8'h2C);
            end else if (r < 29) begin
                send_byte(1'b0, 8'($urandom));
            end else begin
                send_byte(1'b1, 8'($urandom));
            end
            if ($urandom_range(0, 3) == 0) cs_high();
        end
        checkpoint();

        // Reset in the middle of a pixel stream
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22); send_byte(1'b1, 8'h33);
        checkpoint();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        model_reset();
        p0 = px_seen;
        repeat (4) send_byte(1'b1, 8'($urandom));
        checkpoint();
        chk_val("post_rst_ignored", 32'(px_seen - p0), 32'd0);
        send_byte(1'b0, 8'h2C);
        repeat (4) send_byte(1'b1, 8'($urandom));
        checkpoint();
        chk_val("post_rst_px", 32'(px_seen - p0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_display_rx.md
Name: spi_display_rx

Overview:
Responder side of the display SPI link: receives the MOSI/DC/CS/SCLK byte stream produced by the line and shape drawing transmitters and decodes it. Supported commands are SET_COLUMN (0x2A), SET_PAGE (0x2B) and WRITE_RAM (0x2C). Emits one pixel-write strobe per pixel, carrying x, y and 16-bit colour. Used as an on-FPGA display model for loopback self-check and as the bench scoreboard front end for all drawing blocks.

Parameters:
H_RES, 240, column count; x values >= H_RES are flagged as an error.
V_RES, 320, page count; y values >= V_RES are flagged as an error.
SYNC_STAGES, 2, synchroniser depth for i_sclk, i_mosi, i_dc and i_cs (minimum 2).

Ports:
i_clk  in  1  system clock; all logic runs on this clock.
i_rst_n  in  1  asynchronous active-low reset.
i_sclk  in  1  SPI clock, asynchronous to i_clk; data is sampled on its rising edge.
i_mosi  in  1  serial data, MSB first.
i_dc  in  1  0 = command byte, 1 = data byte.
i_cs  in  1  active-low chip select.
o_cmd_valid  out  1  one-cycle pulse when a command byte completes.
o_cmd  out  8  last received command byte.
o_px_valid  out  1  one-cycle pulse per decoded pixel.
o_px_x  out  9  pixel column.
o_px_y  out  9  pixel page.
o_px_color  out  16  pixel colour: {first byte, second byte}.
o_err  out  1  one-cycle pulse on a protocol or range error.

Behaviour:
- Reset (async assert, sync release): every output is 0; window SC=0, EC=H_RES-1, SP=0, EP=V_RES-1; FSM in IDLE; bit count 0.
- Byte assembly:
  - Synchronise all four inputs; detect rising edges of i_sclk on the synchronised signal.
  - On each edge with synchronised cs=0, shift mosi in MSB first.
  - On the 8th bit, latch the byte together with dc as sampled at that same edge.
  - Byte-complete strobe fires exactly 1 i_clk cycle after the synchronised edge.
- CS deassert (0->1) mid-byte: discard the partial byte, pulse o_err, keep the FSM state.
- CS deassert on a byte boundary: no effect; transactions may span several CS frames.
- Command byte (dc=0):
  - Always aborts any parameter or pixel sequence in progress.
  - Pulses o_cmd_valid and updates o_cmd in the same cycle as the byte strobe.
  - Next state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, any other value -> IDLE.
  - Entering RAMWR sets the cursor to x=SC, y=SP and clears the colour-byte phase.
- FSM states: IDLE, CASET, PASET, RAMWR.
- IDLE: data bytes are ignored silently.
- CASET / PASET:
  - Collect 4 data bytes in order: start_hi, start_lo, end_hi, end_lo. Each value is {hi,lo}, truncated to 9 bits.
  - After the 4th byte, commit only if start <= end and end < H_RES (CASET) or end < V_RES (PASET).
  - Otherwise pulse o_err and keep the previous window.
  - Either way, return to IDLE; a 5th data byte is ignored.
- RAMWR:
  - Even bytes are colour_hi, odd bytes are colour_lo.
  - On the colour_lo strobe, o_px_valid pulses for 1 cycle with o_px_x/o_px_y set to the cursor and o_px_color set to the colour.
  - Pixel latency: 1 cycle after the colour_lo byte strobe.
  - Cursor after each pixel: if x==EC then x=SC and y = (y==EP) ? SP : y+1; otherwise x=x+1.
  - The stream is unbounded; wrap-around is silent.
  - A partial pixel (colour_hi only) followed by a command byte is discarded with no o_err.
- o_px_x, o_px_y and o_px_color hold their values between pulses.
- Simultaneous CS deassert and byte completion on the same edge: the byte completes first, then the CS rule applies (boundary, no error).
- Throughput: one byte per 8 SCLK periods; SCLK frequency <= i_clk/4 (SYNC_STAGES=2).

Optional Feature:
SPI_DISPLAY_RX_PIXCNT_EN
- Defined: adds output o_px_count [17:0], the number of pixels since the last 0x2C. Cleared on 0x2C; increments with each o_px_valid; saturates at 2^18-1.
- Not defined: the port is absent; no counter logic is generated.

Decomposition:
- Package spi_display_pkg:
  - Command constants SET_COLUMN=8'h2A, SET_PAGE=8'h2B, WRITE_RAM=8'h2C.
  - Coordinate width 9, colour width 16.
  - FSM state encoding (IDLE, CASET, PASET, RAMWR).
  - Shared with the transmitters.
- Sub-module spi_byte_rx:
  - Contains the synchronisers, SCLK edge detect, shift register and bit counter.
  - Outputs byte[7:0], byte_dc, byte_valid and frame_err.
  - The top level holds the decode FSM and the cursor.

Test Plan:
- Horizontal line: 0x2A {00,0A,00,13}, 0x2B {00,32,00,32}, 0x2C, 20x 0xFF -> 10 pixels, x=10..19, y=50, colour FFFF, 3 o_cmd_valid pulses, no o_err.
- Wrap: same window, 160x 0xFF -> 80 pixels; x cycles 10..19 eight times; y stays at 50.
- Multi-row: window x 0..1, y 5..6, 0x2C, 5 pixels -> (0,5) (1,5) (0,6) (1,6) (0,5).
- Bad window: 0x2A {00,14,00,0A} -> o_err pulse; a following 0x2C pixel lands at x = previous SC.
- CS deassert after 5 bits of a data byte -> o_err pulse, no pixel; the next full byte decodes normally.
- Reset mid-RAMWR (i_rst_n low for 3 cycles) -> all outputs 0, window at full screen, subsequent data bytes ignored until a command arrives.
